// File: rtl/rll_scoreboard_issue.sv
// rll_scoreboard_issue: register-locking issue stage between decode and execute.
// Holds the architectural register file, counts pending writes per register,
// stalls hazardous instructions and presents operands through a valid/ready slice.
// Optional feature macro: RLL_BYPASS_EN (waives a source hazard when the single
// pending write to that source is being written back in the same cycle).
module rll_scoreboard_issue #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int TAG_W    = 4,
    parameter int MAX_PEND = 3,
    localparam int AW      = $clog2(NREGS),
    localparam int LW      = $clog2(MAX_PEND + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [AW-1:0]    rs1_addr,
    input  logic [AW-1:0]    rs2_addr,
    input  logic             use_rs1,
    input  logic             use_rs2,
    input  logic [AW-1:0]    rd_addr,
    input  logic             rd_we,
    input  logic [XLEN-1:0]  imm_in,
    input  logic [XLEN-1:0]  npc_in,
    input  logic [TAG_W-1:0] tag_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  opA,
    output logic [XLEN-1:0]  opB,
    output logic [XLEN-1:0]  opC,
    output logic [XLEN-1:0]  npc_out,
    output logic [TAG_W-1:0] tag_out,
    output logic [AW-1:0]    rd_out,
    output logic             rd_we_out,
    input  logic             wb_valid,
    input  logic [AW-1:0]    wb_addr,
    input  logic [XLEN-1:0]  wb_data,
    input  logic             flush,
    output logic             lock_err
);

    logic [XLEN-1:0]  rf_q [NREGS];
    logic [XLEN-1:0]  rf_d [NREGS];
    logic [LW-1:0]    lock_q [NREGS];
    logic [LW-1:0]    lock_d [NREGS];
    logic [LW:0]      up_s [NREGS];
    logic [LW:0]      dn_s [NREGS];

    logic             out_valid_q, out_valid_d;
    logic [XLEN-1:0]  opa_q, opa_d, opb_q, opb_d, opc_q, opc_d, npc_q, npc_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [AW-1:0]    rd_q, rd_d;
    logic             rd_we_q, rd_we_d;
    logic             lock_err_q, lock_err_d;

    logic src1_lock_s, src2_lock_s, src1_byp_s, src2_byp_s, rd_full_s;
    logic hazard_s, in_ready_s, accept_s, drop_s;

    // Hazard detection and handshake: a source with a pending write, or a destination at the lock limit, stalls.
    always_comb begin
        src1_lock_s = use_rs1 && (rs1_addr != {AW{1'b0}}) && (lock_q[rs1_addr] != {LW{1'b0}});
        src2_lock_s = use_rs2 && (rs2_addr != {AW{1'b0}}) && (lock_q[rs2_addr] != {LW{1'b0}});
`ifdef RLL_BYPASS_EN
        src1_byp_s = src1_lock_s && wb_valid && (wb_addr == rs1_addr) && (lock_q[rs1_addr] == LW'(1));
        src2_byp_s = src2_lock_s && wb_valid && (wb_addr == rs2_addr) && (lock_q[rs2_addr] == LW'(1));
`else
        src1_byp_s = 1'b0;
        src2_byp_s = 1'b0;
`endif
        rd_full_s  = rd_we && (rd_addr != {AW{1'b0}}) && (lock_q[rd_addr] == LW'(MAX_PEND));
        hazard_s   = (src1_lock_s && !src1_byp_s) || (src2_lock_s && !src2_byp_s) || rd_full_s;
        in_ready_s = (!out_valid_q || out_ready) && !hazard_s && !flush;
        accept_s   = in_valid && in_ready_s;
        drop_s     = flush && out_valid_q;
    end

    // Lock counters: +1 on accept, -1 on writeback, -1 on a flushed entry; the sum saturates at zero.
    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            up_s[i] = {1'b0, lock_q[i]};
            dn_s[i] = {(LW + 1){1'b0}};
            if (i != 0) begin
                if (accept_s && rd_we && (rd_addr == AW'(i))) begin
                    up_s[i] = up_s[i] + (LW + 1)'(1);
                end else begin
                    up_s[i] = up_s[i];
                end
                if (wb_valid && (wb_addr == AW'(i))) begin
                    dn_s[i] = dn_s[i] + (LW + 1)'(1);
                end else begin
                    dn_s[i] = dn_s[i];
                end
                if (drop_s && rd_we_q && (rd_q == AW'(i))) begin
                    dn_s[i] = dn_s[i] + (LW + 1)'(1);
                end else begin
                    dn_s[i] = dn_s[i];
                end
            end else begin
                up_s[i] = {(LW + 1){1'b0}};
            end
            if (up_s[i] > dn_s[i]) begin
                lock_d[i] = LW'(up_s[i] - dn_s[i]);
            end else begin
                lock_d[i] = {LW{1'b0}};
            end
        end
        lock_err_d = wb_valid && (wb_addr != {AW{1'b0}}) && (lock_q[wb_addr] == {LW{1'b0}});
    end

    // Register file writeback; r0 stays hard-wired to zero.
    always_comb begin
        rf_d = rf_q;
        if (wb_valid && (wb_addr != {AW{1'b0}})) begin
            rf_d[wb_addr] = wb_data;
        end else begin
            rf_d = rf_q;
        end
    end

    // Output slice: load on accept, empty on consume or flush, otherwise hold.
    always_comb begin
        out_valid_d = out_valid_q;
        opa_d       = opa_q;
        opb_d       = opb_q;
        opc_d       = opc_q;
        npc_d       = npc_q;
        tag_d       = tag_q;
        rd_d        = rd_q;
        rd_we_d     = rd_we_q;
        if (accept_s) begin
            out_valid_d = 1'b1;
            opa_d       = src1_byp_s ? wb_data : rf_q[rs1_addr];
            opb_d       = src2_byp_s ? wb_data : rf_q[rs2_addr];
            opc_d       = imm_in;
            npc_d       = npc_in;
            tag_d       = tag_in;
            rd_d        = rd_addr;
            rd_we_d     = rd_we;
        end else if (drop_s || (out_valid_q && out_ready)) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) begin
                rf_q[i]   <= {XLEN{1'b0}};
                lock_q[i] <= {LW{1'b0}};
            end
            out_valid_q <= 1'b0;
            opa_q       <= {XLEN{1'b0}};
            opb_q       <= {XLEN{1'b0}};
            opc_q       <= {XLEN{1'b0}};
            npc_q       <= {XLEN{1'b0}};
            tag_q       <= {TAG_W{1'b0}};
            rd_q        <= {AW{1'b0}};
            rd_we_q     <= 1'b0;
            lock_err_q  <= 1'b0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                rf_q[i]   <= rf_d[i];
                lock_q[i] <= lock_d[i];
            end
            out_valid_q <= out_valid_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            opc_q       <= opc_d;
            npc_q       <= npc_d;
            tag_q       <= tag_d;
            rd_q        <= rd_d;
            rd_we_q     <= rd_we_d;
            lock_err_q  <= lock_err_d;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_q;
    assign opA       = opa_q;
    assign opB       = opb_q;
    assign opC       = opc_q;
    assign npc_out   = npc_q;
    assign tag_out   = tag_q;
    assign rd_out    = rd_q;
    assign rd_we_out = rd_we_q;
    assign lock_err  = lock_err_q;

endmodule
